// File: rtl/router_pkg.sv
// Shared types and header field layout for the router input arbiter.
package router_pkg;

    localparam int         LEN_W        = 6;
    localparam logic [1:0] ADDR_INVALID = 2'b11;
    localparam int         HDR_LEN_MSB  = 7;
    localparam int         HDR_LEN_LSB  = 2;
    localparam int         HDR_ADDR_MSB = 1;
    localparam int         HDR_ADDR_LSB = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PLD,
        PAR,
        DROP,
        GAP
    } state_t;

    function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
    endfunction

endpackage

// File: rtl/router_in_arb_if.sv
// Source-side and router-side signals of the input arbiter.
// A source byte moves when ack_i is high at a rising edge; the source then presents the next byte.
interface router_in_arb_if;
    logic       req_0, req_1, req_2;
    logic [7:0] src_data_0, src_data_1, src_data_2;
    logic       gnt_0, gnt_1, gnt_2;
    logic       ack_0, ack_1, ack_2;
    logic       rtr_busy;
    logic [7:0] rtr_data;
    logic       rtr_pkt_valid;
    logic       drop_pulse;
    logic       abort_pulse;

    modport slave (
        input  req_0, req_1, req_2, src_data_0, src_data_1, src_data_2, rtr_busy,
        output gnt_0, gnt_1, gnt_2, ack_0, ack_1, ack_2,
               rtr_data, rtr_pkt_valid, drop_pulse, abort_pulse
    );

    modport master (
        output req_0, req_1, req_2, src_data_0, src_data_1, src_data_2, rtr_busy,
        input  gnt_0, gnt_1, gnt_2, ack_0, ack_1, ack_2,
               rtr_data, rtr_pkt_valid, drop_pulse, abort_pulse
    );
endinterface

// File: rtl/router_rr_arb3.sv
// Three-way round-robin pick: search starts one past the previous winner.
module router_rr_arb3 (
    input  logic [2:0] req,
    input  logic [1:0] last_winner,
    output logic [2:0] winner,
    output logic [1:0] winner_idx
);

    logic [1:0] first, second, third;

    always_comb begin
        case (last_winner)
            2'd0:    begin first = 2'd1; second = 2'd2; third = 2'd0; end
            2'd1:    begin first = 2'd2; second = 2'd0; third = 2'd1; end
            default: begin first = 2'd0; second = 2'd1; third = 2'd2; end
        endcase
    end

    always_comb begin
        winner     = 3'b000;
        winner_idx = last_winner;
        if (req[first]) begin
            winner     = 3'b001 << first;
            winner_idx = first;
        end else if (req[second]) begin
            winner     = 3'b001 << second;
            winner_idx = second;
        end else if (req[third]) begin
            winner     = 3'b001 << third;
            winner_idx = third;
        end
    end

endmodule

// File: rtl/router_in_arb.sv
// Arbitrates three packet sources onto one router input, draining address-3
// packets and padding out packets whose source withdraws mid-flight.
module router_in_arb
    import router_pkg::*;
#(
    parameter int IDLE_GAP = 2
) (
    input  logic           clock,
    input  logic           resetn,
    router_in_arb_if.slave bus,
    output state_t         state_dbg
);

    localparam logic [3:0] GAP_LOAD = 4'(IDLE_GAP - 1);

    state_t           state_q, state_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [1:0]       last_q, last_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W:0]   drop_q, drop_d;
    logic [3:0]       gap_q, gap_d;
    logic             abort_q, abort_d;

    logic [2:0] req_v, winner, ack_v;
    logic [1:0] winner_idx;
    logic [7:0] src_gnt, win_data, data_d;
    logic       req_gnt, in_pkt, abort_now, accept, valid_d, drop_p, abort_p;

    assign req_v = {bus.req_2, bus.req_1, bus.req_0};

    router_rr_arb3 u_rr (
        .req        (req_v),
        .last_winner(last_q),
        .winner     (winner),
        .winner_idx (winner_idx)
    );

    always_comb begin
        src_gnt = 8'h00;
        if (gnt_q[0])      src_gnt = bus.src_data_0;
        else if (gnt_q[1]) src_gnt = bus.src_data_1;
        else if (gnt_q[2]) src_gnt = bus.src_data_2;
        win_data = 8'h00;
        if (winner[0])      win_data = bus.src_data_0;
        else if (winner[1]) win_data = bus.src_data_1;
        else if (winner[2]) win_data = bus.src_data_2;
    end

    assign req_gnt   = |(gnt_q & req_v);
    assign in_pkt    = (state_q == HDR) || (state_q == PLD) || (state_q == PAR);
    assign abort_now = in_pkt && (abort_q || !req_gnt);
    assign accept    = (in_pkt && !bus.rtr_busy) || (state_q == DROP);
    assign ack_v     = gnt_q & {3{accept && !abort_now}};

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        count_d = count_q;
        drop_d  = drop_q;
        gap_d   = gap_q;
        abort_d = abort_q;
        data_d  = 8'h00;
        valid_d = 1'b0;
        drop_p  = 1'b0;
        abort_p = in_pkt && !abort_q && !req_gnt;
        case (state_q)
            IDLE: begin
                if (|req_v) begin
                    // Header is held by the source until acked, so the length can be taken at grant.
                    gnt_d   = winner;
                    last_d  = winner_idx;
                    count_d = hdr_len(win_data);
                    drop_d  = {1'b0, hdr_len(win_data)} + (LEN_W+1)'(2);
                    abort_d = 1'b0;
                    state_d = (hdr_addr(win_data) == ADDR_INVALID) ? DROP : HDR;
                end
            end
            HDR: begin
                valid_d = 1'b1;
                data_d  = abort_now ? 8'h00 : src_gnt;
                if (accept) state_d = (count_q == '0) ? PAR : PLD;
            end
            PLD: begin
                valid_d = 1'b1;
                data_d  = abort_now ? 8'h00 : src_gnt;
                if (accept) begin
                    count_d = count_q - LEN_W'(1);
                    if (count_q == LEN_W'(1)) state_d = PAR;
                end
            end
            PAR: begin
                data_d = abort_now ? 8'h00 : src_gnt;
                if (accept) begin
                    state_d = GAP;
                    gnt_d   = 3'b000;
                    gap_d   = GAP_LOAD;
                end
            end
            DROP: begin
                if (drop_q == (LEN_W+1)'(1)) begin
                    drop_p  = 1'b1;
                    state_d = GAP;
                    gnt_d   = 3'b000;
                    gap_d   = GAP_LOAD;
                end else begin
                    drop_d = drop_q - (LEN_W+1)'(1);
                end
            end
            GAP: begin
                if (gap_q == 4'd0) state_d = IDLE;
                else               gap_d   = gap_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
        if (abort_p) abort_d = 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            gnt_q   <= 3'b000;
            last_q  <= 2'd2;
            count_q <= '0;
            drop_q  <= '0;
            gap_q   <= 4'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            count_q <= count_d;
            drop_q  <= drop_d;
            gap_q   <= gap_d;
            abort_q <= abort_d;
        end
    end

    assign {bus.gnt_2, bus.gnt_1, bus.gnt_0} = gnt_q;
    assign {bus.ack_2, bus.ack_1, bus.ack_0} = ack_v;
    assign bus.rtr_data      = data_d;
    assign bus.rtr_pkt_valid = valid_d;
    assign bus.drop_pulse    = drop_p;
    assign bus.abort_pulse   = abort_p;
    assign state_dbg         = state_q;

endmodule

// File: tb/tb_router_in_arb.sv
// Bench for router_in_arb: packet-level reference model checked every cycle,
// directed scenarios with hand-computed totals, then randomized traffic.
module tb_router_in_arb;
  import router_pkg::*;

  localparam int IDLE_GAP = 2;

  logic   clock;
  logic   resetn;
  state_t state_dbg;

  router_in_arb_if bus ();

  router_in_arb #(.IDLE_GAP(IDLE_GAP)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .bus      (bus),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // source byte streams; front of each queue is the byte on src_data_i
  logic [7:0] src_q[3][$];

  // packet-level reference: owner, byte position, aborted flag, gap left
  int m_owner, m_pos, m_len, m_gap, m_last;
  bit m_drop, m_abort;

  int n_tests, n_fail;
  int n_ack[3];
  int n_valid, n_drop, n_abort, n_overlap, n_gap_cyc, n_zero_valid, n_zero_par;
  int busy_acks, busy_changes;
  bit prev_busy_valid, prev_busy_v;
  logic [7:0] prev_busy_data;
  logic [2:0] prev_gnt;
  int gnt_order[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int rr_pick(input logic [2:0] rq, input int last);
    for (int k = 1; k <= 3; k++) begin
      int c;
      c = (last + k) % 3;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  // driver tasks
  task automatic drive_inputs();
    bus.req_0      = (src_q[0].size() > 0);
    bus.req_1      = (src_q[1].size() > 0);
    bus.req_2      = (src_q[2].size() > 0);
    bus.src_data_0 = (src_q[0].size() > 0) ? src_q[0][0] : 8'h00;
    bus.src_data_1 = (src_q[1].size() > 0) ? src_q[1][0] : 8'h00;
    bus.src_data_2 = (src_q[2].size() > 0) ? src_q[2][0] : 8'h00;
  endtask

  task automatic push_pkt(input int s, input int len, input int addr);
    logic [7:0] h, p, b;
    h = {6'(len), 2'(addr)};
    src_q[s].push_back(h);
    p = h;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(1, 255));
      src_q[s].push_back(b);
      p = p ^ b;
    end
    src_q[s].push_back(p);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 3; i++) n_ack[i] = 0;
    n_valid = 0; n_drop = 0; n_abort = 0; n_overlap = 0; n_gap_cyc = 0;
    n_zero_valid = 0; n_zero_par = 0; busy_acks = 0; busy_changes = 0;
    prev_busy_valid = 0; prev_gnt = 3'b000;
    gnt_order.delete();
  endtask

  task automatic model_reset();
    m_owner = -1; m_pos = 0; m_len = 0; m_gap = 0; m_last = 2;
    m_drop = 0; m_abort = 0;
  endtask

  function automatic bit all_idle();
    return (m_owner < 0) && (m_gap == 0) && (src_q[0].size() == 0) &&
           (src_q[1].size() == 0) && (src_q[2].size() == 0);
  endfunction

  // One clock: compare at negedge against the model, advance model, pop sources after the edge.
  task automatic cycle();
    logic [2:0] rq, e_gnt, e_ack, a_gnt, a_ack;
    logic [7:0] sd[3];
    logic [7:0] e_data;
    logic e_valid, e_drp, e_abt;
    bit ab_now, acc;
    @(negedge clock);
    rq    = {bus.req_2, bus.req_1, bus.req_0};
    sd[0] = bus.src_data_0; sd[1] = bus.src_data_1; sd[2] = bus.src_data_2;
    e_gnt = 3'b000; e_ack = 3'b000; e_data = 8'h00;
    e_valid = 1'b0; e_drp = 1'b0; e_abt = 1'b0;
    if (m_gap > 0) begin
      m_gap--;
    end else if (m_owner < 0) begin
      if (rq != 3'b000) begin
        m_owner = rr_pick(rq, m_last);
        m_last  = m_owner;
        m_pos   = 0;
        m_len   = int'(sd[m_owner][7:2]);
        m_drop  = (sd[m_owner][1:0] == 2'b11);
        m_abort = 0;
      end
    end else if (m_drop) begin
      e_gnt[m_owner] = 1'b1;
      e_ack[m_owner] = 1'b1;
      e_drp = (m_pos == m_len + 1);
      if (e_drp) begin m_owner = -1; m_gap = IDLE_GAP; end
      else m_pos++;
    end else begin
      e_gnt[m_owner] = 1'b1;
      ab_now  = m_abort || !rq[m_owner];
      e_abt   = !m_abort && !rq[m_owner];
      e_valid = (m_pos <= m_len);
      e_data  = ab_now ? 8'h00 : sd[m_owner];
      acc     = !bus.rtr_busy;
      e_ack[m_owner] = acc && !ab_now;
      if (ab_now) m_abort = 1;
      if (acc) begin
        if (m_pos == m_len + 1) begin m_owner = -1; m_gap = IDLE_GAP; end
        else m_pos++;
      end
    end

    a_gnt = {bus.gnt_2, bus.gnt_1, bus.gnt_0};
    a_ack = {bus.ack_2, bus.ack_1, bus.ack_0};
    check("gnt", 32'(a_gnt), 32'(e_gnt));
    check("ack", 32'(a_ack), 32'(e_ack));
    check("rtr_data", 32'(bus.rtr_data), 32'(e_data));
    check("rtr_pkt_valid", 32'(bus.rtr_pkt_valid), 32'(e_valid));
    check("drop_pulse", 32'(bus.drop_pulse), 32'(e_drp));
    check("abort_pulse", 32'(bus.abort_pulse), 32'(e_abt));

    for (int i = 0; i < 3; i++) n_ack[i] += int'(a_ack[i]);
    n_valid += int'(bus.rtr_pkt_valid);
    n_drop  += int'(bus.drop_pulse);
    n_abort += int'(bus.abort_pulse);
    if ($countones(a_gnt) > 1) n_overlap++;
    if (state_dbg == GAP) n_gap_cyc++;
    if (a_gnt != 0 && bus.rtr_data == 8'h00 && bus.rtr_pkt_valid) n_zero_valid++;
    if (a_gnt != 0 && bus.rtr_data == 8'h00 && !bus.rtr_pkt_valid) n_zero_par++;
    if (a_gnt != 0 && prev_gnt == 0) begin
      for (int i = 0; i < 3; i++) if (a_gnt[i]) gnt_order.push_back(i);
    end
    prev_gnt = a_gnt;
    if (bus.rtr_busy && a_gnt != 0) begin
      busy_acks += $countones(a_ack);
      if (prev_busy_valid && (bus.rtr_data !== prev_busy_data || bus.rtr_pkt_valid !== prev_busy_v))
        busy_changes++;
      prev_busy_valid = 1;
      prev_busy_data  = bus.rtr_data;
      prev_busy_v     = bus.rtr_pkt_valid;
    end else begin
      prev_busy_valid = 0;
    end

    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) if (e_ack[i]) void'(src_q[i].pop_front());
    drive_inputs();
  endtask

  // Reset asserted between edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    #1 resetn = 1'b0;
    #1;
    check("rst_gnt", 32'({bus.gnt_2, bus.gnt_1, bus.gnt_0}), 32'h0);
    check("rst_ack", 32'({bus.ack_2, bus.ack_1, bus.ack_0}), 32'h0);
    check("rst_data", 32'(bus.rtr_data), 32'h0);
    check("rst_valid", 32'(bus.rtr_pkt_valid), 32'h0);
    check("rst_pulses", 32'({bus.drop_pulse, bus.abort_pulse}), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    for (int i = 0; i < 3; i++) src_q[i].delete();
    bus.rtr_busy = 1'b0;
    model_reset();
    drive_inputs();
    repeat (2) @(posedge clock);
    #1 resetn = 1'b1;
  endtask

  // Run until all traffic drains; optional busy window or source withdrawal at a byte position.
  task automatic run_until_idle(input int busy_pos, input int abort_pos);
    int cnt, busy_left;
    bit busy_done, abort_done;
    cnt = 0; busy_left = 0; busy_done = 0; abort_done = 0;
    while (!all_idle() && cnt < 600) begin
      if (!busy_done && m_owner >= 0 && m_pos == busy_pos) begin
        bus.rtr_busy = 1'b1; busy_left = 3; busy_done = 1;
      end
      if (!abort_done && m_owner >= 0 && m_pos == abort_pos) begin
        src_q[m_owner].delete(); abort_done = 1;
        drive_inputs();
      end
      cycle();
      cnt++;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.rtr_busy = 1'b0;
      end
    end
    check("drain_timeout", 32'(all_idle()), 32'h1);
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    resetn = 1'b1;
    bus.rtr_busy = 1'b0;
    model_reset();
    drive_inputs();
    clear_stats();
    do_reset();

    // single source, len 3 addr 1
    clear_stats();
    src_q[0].push_back(8'h0D);
    src_q[0].push_back(8'h11); src_q[0].push_back(8'h22); src_q[0].push_back(8'h33);
    src_q[0].push_back(8'h0D ^ 8'h11 ^ 8'h22 ^ 8'h33);
    drive_inputs();
    run_until_idle(-1, -1);
    check("single_acks", 32'(n_ack[0]), 32'd5);
    check("single_valid_cycles", 32'(n_valid), 32'd4);
    check("single_gap_cycles", 32'(n_gap_cyc), 32'd2);
    check("single_grants", 32'(gnt_order.size()), 32'd1);

    // three sources, len 1 each, source 0 queues a second packet
    do_reset();
    clear_stats();
    push_pkt(0, 1, 0); push_pkt(0, 1, 0);
    push_pkt(1, 1, 1);
    push_pkt(2, 1, 2);
    drive_inputs();
    run_until_idle(-1, -1);
    check("rr_grants", 32'(gnt_order.size()), 32'd4);
    if (gnt_order.size() == 4) begin
      check("rr_order0", 32'(gnt_order[0]), 32'd0);
      check("rr_order1", 32'(gnt_order[1]), 32'd1);
      check("rr_order2", 32'(gnt_order[2]), 32'd2);
      check("rr_order3", 32'(gnt_order[3]), 32'd0);
    end
    check("rr_overlap", 32'(n_overlap), 32'd0);
    check("rr_gap_cycles", 32'(n_gap_cyc), 32'd8);
    check("rr_valid_cycles", 32'(n_valid), 32'd8);

    // busy for 3 cycles in the middle of a len-4 payload
    do_reset();
    clear_stats();
    push_pkt(1, 4, 2);
    drive_inputs();
    run_until_idle(2, -1);
    check("busy_acks_while_busy", 32'(busy_acks), 32'd0);
    check("busy_stable", 32'(busy_changes), 32'd0);
    check("busy_total_acks", 32'(n_ack[1]), 32'd6);
    check("busy_valid_cycles", 32'(n_valid), 32'd8);

    // address-3 packet is drained, next source follows after the gap
    do_reset();
    clear_stats();
    src_q[0].push_back(8'h0B);
    src_q[0].push_back(8'h5A); src_q[0].push_back(8'hA5); src_q[0].push_back(8'h0B ^ 8'h5A ^ 8'hA5);
    push_pkt(1, 0, 1);
    drive_inputs();
    run_until_idle(-1, -1);
    check("drop_acks", 32'(n_ack[0]), 32'd4);
    check("drop_pulses", 32'(n_drop), 32'd1);
    check("drop_valid_cycles", 32'(n_valid), 32'd1);
    check("drop_grants", 32'(gnt_order.size()), 32'd2);
    if (gnt_order.size() == 2) check("drop_next_src", 32'(gnt_order[1]), 32'd1);

    // source 1 withdraws after one payload byte of len 4
    do_reset();
    clear_stats();
    push_pkt(1, 4, 1);
    drive_inputs();
    run_until_idle(-1, 2);
    check("abort_pulses", 32'(n_abort), 32'd1);
    check("abort_acks", 32'(n_ack[1]), 32'd2);
    check("abort_zero_payload", 32'(n_zero_valid), 32'd3);
    check("abort_zero_parity", 32'(n_zero_par), 32'd1);
    check("abort_gap_cycles", 32'(n_gap_cyc), 32'd2);

    // reset while in payload, then source 0 must win first
    do_reset();
    clear_stats();
    push_pkt(0, 5, 1);
    drive_inputs();
    for (int c = 0; c < 20 && !(m_owner == 0 && m_pos == 2); c++) cycle();
    check("mid_reset_reached_pld", 32'(state_dbg), 32'(PLD));
    do_reset();
    clear_stats();
    push_pkt(2, 1, 2);
    push_pkt(0, 1, 0);
    drive_inputs();
    run_until_idle(-1, -1);
    check("post_reset_grants", 32'(gnt_order.size()), 32'd2);
    if (gnt_order.size() == 2) check("post_reset_first", 32'(gnt_order[0]), 32'd0);
    check("post_reset_pulses", 32'(n_drop + n_abort), 32'd0);

    // randomized traffic
    clear_stats();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        if (i != m_owner && src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
          push_pkt(i, ($urandom_range(0, 19) == 0) ? 63 : int'($urandom_range(0, 6)),
                   int'($urandom_range(0, 3)));
      end
      if (m_owner >= 0 && !m_drop && !m_abort && $urandom_range(0, 60) == 0)
        src_q[m_owner].delete();
      bus.rtr_busy = ($urandom_range(0, 3) == 0);
      drive_inputs();
      cycle();
    end
    bus.rtr_busy = 1'b0;
    run_until_idle(-1, -1);
    check("random_overlap", 32'(n_overlap), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/router_in_arb.md
ROUTER_IN_ARB -- requirements
Module: router_in_arb

Interface
REQ-001 Parameter IDLE_GAP, default 2, number of cycles rtr_pkt_valid SHALL stay low between packets (range 1..15).
REQ-002 clock  input  1  single clock; all state updates on the rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 req_0/req_1/req_2  input  1 each  source i has a packet; held high from header until its parity byte is acked.
REQ-005 src_data_0/1/2  input  8 each  current byte of source i; byte 0 is the header: [7:2] payload length, [1:0] destination address.
REQ-006 gnt_0/1/2  output  1 each  source i owns the router input (one-hot or zero).
REQ-007 ack_0/1/2  output  1 each  current byte of source i consumed this cycle; source advances on that edge.
REQ-008 rtr_busy  input  1  router busy; no byte accepted while high.
REQ-009 rtr_data  output  8  byte to router data_in.
REQ-010 rtr_pkt_valid  output  1  to router pkt_valid.
REQ-011 drop_pulse  output  1  one-cycle pulse when an address-3 packet finishes draining.
REQ-012 abort_pulse  output  1  one-cycle pulse when the granted req falls mid-packet.

Function
REQ-013 States SHALL be IDLE, HDR, PLD, PAR, DROP, GAP.
REQ-014 Accept = state in {HDR,PLD,PAR} and rtr_busy==0, or state==DROP; ack_i = gnt_i & accept, combinational.
REQ-015 IDLE: when any req is high, the winner is chosen round-robin starting at (last_winner+1) mod 3; gnt registered next edge.
REQ-016 IDLE: winner header [1:0]==2'b11 -> DROP; else -> HDR; last_winner updated on grant.
REQ-017 HDR: rtr_data=header, rtr_pkt_valid=1; on accept latch length; length 0 -> PAR, else -> PLD with count=length.
REQ-018 PLD: rtr_data=src byte, rtr_pkt_valid=1; each accept decrements count; accept at count==1 -> PAR.
REQ-019 PAR: rtr_data=src byte (parity), rtr_pkt_valid=0; on accept -> GAP, gnt cleared.
REQ-020 DROP: rtr_pkt_valid=0, rtr_data=8'h00; ack every cycle for length+2 bytes (header, payload, parity); then drop_pulse, -> GAP.
REQ-021 GAP: rtr_pkt_valid=0 for exactly IDLE_GAP cycles, then -> IDLE; new reqs wait.
REQ-022 rtr_data and rtr_pkt_valid SHALL be held stable while rtr_busy is high.
REQ-023 Granted req falling in HDR/PLD/PAR: abort_pulse once, ack suppressed, remaining payload driven 8'h00 with pkt_valid=1, parity driven 8'h00 with pkt_valid=0, then GAP.
REQ-024 Requests arriving in non-IDLE states SHALL not preempt; length count SHALL be 6-bit, no wrap beyond 63.
REQ-025 rtr_data SHALL be 8'h00 in IDLE and GAP.

Reset
REQ-026 resetn low SHALL immediately force: state IDLE, gnt_* 0, ack_* 0, rtr_pkt_valid 0, rtr_data 0, pulses 0, count 0, last_winner 2 (source 0 first), gap counter satisfied.
REQ-027 Reset mid-packet SHALL discard the packet; no pulse issued.

Structure
REQ-028 Shared package router_pkg SHALL hold the state enum, ADDR_INVALID=2'b11, header field positions, LEN_W=6.
REQ-029 Round-robin selection SHALL live in sub-module router_rr_arb3 (3 reqs, last_winner in, one-hot winner out).

Verification
REQ-030 req_0 only, header 8'h0D (len 3, addr 1), busy low -> gnt_0, pkt_valid high 4 cycles, low on parity, 5 acks, then 2 low cycles.
REQ-031 req_0..2 all high, len 1 each -> grant order 0,1,2,0; no gnt overlap; gap of 2 between packets.
REQ-032 rtr_busy high 3 cycles mid-payload -> no ack, rtr_data/pkt_valid stable, count unchanged, resume after.
REQ-033 header 8'h0B (len 2, addr 3) -> rtr_pkt_valid never high, 4 acks, drop_pulse once, next source granted after gap.
REQ-034 req_1 drops after 1 payload byte of len 4 -> abort_pulse, 3 bytes 8'h00 with pkt_valid, parity 8'h00, GAP.
REQ-035 resetn low during PLD -> all outputs 0 asynchronously; after release source 0 wins first.
